// File: rtl/lcd_feed_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcd_feed_pkg
// Brief    : Shared types and constants for the LCD feed monitor block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcd_feed_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } feed_state_e;

  // Active-low {g,f,e,d,c,b,a} patterns; element 0 is the glyph for nibble 0.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
    return SEG7_LUT[nibble];
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
//------------------------------------------------------------------------------
// Module   : seg7_decode
// Brief    : Hex nibble plus active-low decimal point to active-low 7-seg byte.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_decode
  import lcd_feed_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       dp_n_i,
  output logic [7:0] seg_o
);

  assign seg_o = {dp_n_i, seg7_lookup(nibble_i)};

endmodule

`default_nettype wire

// File: rtl/lcd_feed_monitor.sv
//------------------------------------------------------------------------------
// Module   : lcd_feed_monitor
// Brief    : FIFO-to-LCD-host adapter, LED counter and three hex digit decoders.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcd_feed_monitor
  import lcd_feed_pkg::*;
#(
  parameter int FIFO_W = 9,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  input  logic [FIFO_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  input  logic              init_done,
  input  logic              host_ready,
  output logic              host_valid,
  output logic              host_rs,
  output logic [7:0]        host_data,
  input  logic [CNT_W-1:0]  cnt_d_in,
  input  logic              cnt_set,
  input  logic              cnt_en,
  output logic [CNT_W-1:0]  cnt_q,
  input  logic [11:0]       disp_value,
  input  logic [2:0]        disp_dp,
  output logic [7:0]        hex0,
  output logic [7:0]        hex1,
  output logic [7:0]        hex2
);

  feed_state_e       state_q, state_d;
  logic [8:0]        host_word_q, host_word_d;
  logic [CNT_W-1:0]  cnt_val_q, cnt_val_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // init_done and fifo_empty only matter in IDLE; once popped, a word always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_done && !fifo_empty) state_d = POP;
      POP:     state_d = WAIT;
      WAIT:    state_d = SEND;
      SEND:    if (host_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_rd_en = 1'b0;
    host_valid = 1'b0;
    case (state_q)
      POP:     fifo_rd_en = 1'b1;
      SEND:    host_valid = 1'b1;
      default: ;
    endcase
  end

  // FIFO read data is valid in WAIT, the cycle after the pop strobe.
  assign host_word_d = (state_q == WAIT) ? {fifo_dout[FIFO_W-1], fifo_dout[7:0]}
                                         : host_word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_word_q <= '0;
    end else begin
      host_word_q <= host_word_d;
    end
  end

  assign host_rs   = host_word_q[8];
  assign host_data = host_word_q[7:0];

  always_comb begin
    cnt_val_d = cnt_val_q;
    if (cnt_set) begin
      cnt_val_d = cnt_d_in;
    end else if (cnt_en) begin
      cnt_val_d = cnt_val_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val_q <= '0;
    end else begin
      cnt_val_q <= cnt_val_d;
    end
  end

  assign cnt_q = cnt_val_q;

  seg7_decode u_hex0 (
    .nibble_i (disp_value[3:0]),
    .dp_n_i   (disp_dp[0]),
    .seg_o    (hex0)
  );

  seg7_decode u_hex1 (
    .nibble_i (disp_value[7:4]),
    .dp_n_i   (disp_dp[1]),
    .seg_o    (hex1)
  );

  seg7_decode u_hex2 (
    .nibble_i (disp_value[11:8]),
    .dp_n_i   (disp_dp[2]),
    .seg_o    (hex2)
  );

endmodule

`default_nettype wire

// File: tb/tb_lcd_feed_monitor.sv
//------------------------------------------------------------------------------
// Module   : tb_lcd_feed_monitor
// Brief    : Self-checking bench for lcd_feed_monitor (FIFO model + scoreboard).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_feed_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic [8:0]  fifo_dout;
  logic        fifo_rd_en;
  logic        init_done;
  logic        host_ready;
  logic        host_valid;
  logic        host_rs;
  logic [7:0]  host_data;
  logic [7:0]  cnt_d_in;
  logic        cnt_set;
  logic        cnt_en;
  logic [7:0]  cnt_q;
  logic [11:0] disp_value;
  logic [2:0]  disp_dp;
  logic [7:0]  hex0, hex1, hex2;

  always #5 clk = ~clk;

  lcd_feed_monitor #(.FIFO_W(9), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .init_done  (init_done),
    .host_ready (host_ready),
    .host_valid (host_valid),
    .host_rs    (host_rs),
    .host_data  (host_data),
    .cnt_d_in   (cnt_d_in),
    .cnt_set    (cnt_set),
    .cnt_en     (cnt_en),
    .cnt_q      (cnt_q),
    .disp_value (disp_value),
    .disp_dp    (disp_dp),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2)
  );

  int         checks = 0;
  int         errors = 0;
  logic [8:0] q[$];
  logic [8:0] sb[$];
  int         pop_cyc[$];
  int         npops = 0, ndeliv = 0, since = 0, cyc_no = 0, cnt_m = 0;
  bit         busy = 0, acc = 0, rd_seen = 0, pv = 0;
  logic [8:0] pw;
  logic [6:0] seg_tab [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_hex(input logic [3:0] nib, input logic dp);
    return {dp, seg_tab[nib]};
  endfunction

  // Sampled after the falling edge: outputs stable, inputs as the next rising edge sees them.
  task automatic pre();
    logic [31:0] want;
    if (fifo_rd_en === 1'b1) begin
      check("pop_while_busy", {31'b0, busy}, 32'd0);
      npops++;
      pop_cyc.push_back(cyc_no);
      busy    = 1;
      since   = 0;
      rd_seen = 1;
    end else begin
      rd_seen = 0;
    end
    acc = 0;
    if (host_valid === 1'b1 && host_ready) begin
      want = (sb.size() > 0) ? {23'b0, sb.pop_front()} : 32'hDEAD_BEEF;
      check("delivered_word", {23'b0, host_rs, host_data}, want);
      busy = 0;
      acc  = 1;
      ndeliv++;
    end
    if (cnt_set)     cnt_m = int'(cnt_d_in);
    else if (cnt_en) cnt_m = (cnt_m + 1) % 256;
  endtask

  task automatic post();
    check("hex0", hex0, exp_hex(disp_value[3:0],  disp_dp[0]));
    check("hex1", hex1, exp_hex(disp_value[7:4],  disp_dp[1]));
    check("hex2", hex2, exp_hex(disp_value[11:8], disp_dp[2]));
    check("cnt_q", cnt_q, cnt_m);
    if (acc) check("valid_drop_after_accept", host_valid, 0);
    if (busy) since++;
    if (host_valid === 1'b1 && !pv) check("valid_latency", since, 2);
    if (host_valid === 1'b1 && pv && !acc) check("hold_stable", {host_rs, host_data}, pw);
    if (host_valid === 1'b1) check("valid_has_word", {31'b0, busy}, 1);
    pv = host_valid;
    pw = {host_rs, host_data};
  endtask

  // One clock: FIFO model answers a pop the cycle after the strobe.
  task automatic cyc();
    pre();
    @(posedge clk);
    #1;
    cyc_no++;
    if (rd_seen) begin
      if (q.size() > 0) begin
        fifo_dout = q.pop_front();
        sb.push_back(fifo_dout);
      end else begin
        fifo_dout = 9'h1FF;
      end
    end
    fifo_empty = (q.size() == 0);
    @(negedge clk);
    post();
  endtask

  task automatic push(input logic [8:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  initial begin
    int base;
    bit done;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst_n = 1'b0; fifo_empty = 1'b1; fifo_dout = '0; init_done = 1'b0;
    host_ready = 1'b0; cnt_d_in = '0; cnt_set = 1'b0; cnt_en = 1'b0;
    disp_value = '0; disp_dp = 3'b111;
    repeat (2) @(negedge clk);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_valid", host_valid, 0);
    check("rst_rs",    host_rs,    0);
    check("rst_data",  host_data,  0);
    check("rst_cnt",   cnt_q,      0);
    rst_n = 1'b1;

    // init_done gates the pop
    push(9'h141);
    base = npops;
    repeat (20) cyc();
    check("no_pop_before_init", npops - base, 0);
    init_done = 1'b1;
    cyc();
    check("pop_after_init", fifo_rd_en, 1);
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", host_valid, 1);
      check("stall_rs",    host_rs,    1);
      check("stall_data",  host_data,  8'h41);
      cyc();
    end
    host_ready = 1'b1;
    cyc();
    check("valid_low_after_ready", host_valid, 0);

    // back-to-back delivery spacing
    pop_cyc.delete();
    base = ndeliv;
    push(9'h038); push(9'h00C); push(9'h148);
    repeat (30) cyc();
    check("three_pops", pop_cyc.size(), 3);
    check("three_delivered", ndeliv - base, 3);
    if (pop_cyc.size() == 3) begin
      check("spacing_1", pop_cyc[1] - pop_cyc[0], 4);
      check("spacing_2", pop_cyc[2] - pop_cyc[1], 4);
    end
    host_ready = 1'b0;

    // counter
    cnt_set = 1'b1; cnt_d_in = 8'hFE;
    cyc(); check("cnt_load", cnt_q, 8'hFE);
    cnt_set = 1'b0; cnt_en = 1'b1;
    cyc(); check("cnt_ff", cnt_q, 8'hFF);
    cyc(); check("cnt_wrap", cnt_q, 8'h00);
    cyc(); check("cnt_01", cnt_q, 8'h01);
    cnt_set = 1'b1; cnt_d_in = 8'h10;
    cyc(); check("cnt_set_prio", cnt_q, 8'h10);
    cnt_set = 1'b0; cnt_en = 1'b0;

    // display
    disp_value = 12'hA50; disp_dp = 3'b111;
    #1;
    check("disp_hex0", hex0, 8'hC0);
    check("disp_hex1", hex1, 8'h92);
    check("disp_hex2", hex2, 8'h88);
    disp_dp = 3'b110;
    #1;
    check("disp_hex0_dp", hex0, 8'h40);
    cyc();

    // async reset in the middle of SEND
    push(9'h0AB);
    done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc();
      done = (host_valid === 1'b1);
    end
    check("reach_send", {31'b0, done}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", host_valid, 0);
    check("mid_rst_rd_en", fifo_rd_en, 0);
    check("mid_rst_rs",    host_rs,    0);
    check("mid_rst_data",  host_data,  0);
    check("mid_rst_cnt",   cnt_q,      0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    sb.delete(); busy = 0; acc = 0; rd_seen = 0; pv = 0; cnt_m = 0; since = 0;
    init_done = 1'b1;
    cyc();
    cyc();
    check("post_rst_idle_valid", host_valid, 0);
    check("post_rst_idle_rd_en", fifo_rd_en, 0);
    push(9'h155);
    cyc();
    check("post_rst_pop", fifo_rd_en, 1);
    host_ready = 1'b1;
    repeat (6) cyc();

    // randomized traffic against the scoreboard
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0 && q.size() < 8) push(9'($urandom));
      init_done  = ($urandom_range(7) != 0);
      host_ready = $urandom_range(1) == 1;
      cnt_set    = ($urandom_range(15) == 0);
      cnt_en     = $urandom_range(1) == 1;
      cnt_d_in   = 8'($urandom);
      disp_value = 12'($urandom);
      disp_dp    = 3'($urandom);
      cyc();
    end
    init_done = 1'b1; host_ready = 1'b1; cnt_set = 1'b0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      cyc();
      done = (q.size() == 0 && sb.size() == 0 && !busy);
    end
    check("drain_complete", {31'b0, done}, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
